// File: rtl/reset_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | reset_sequencer: debounced button / soft request / FPGA-start driven       |
// | staggered multi-channel reset release. Optional macro: RESET_SEQUENCER_CAUSE_EN |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module reset_sequencer #(
  parameter int HOLD_CYCLES     = 500000,
  parameter int DEBOUNCE_CYCLES = 10000,
  parameter int NUM_CH          = 3,
  parameter int STAGGER_CYCLES  = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fpga_but1,
  input  logic              fpgaStart,
  input  logic              ext_req,
  output logic [NUM_CH-1:0] reset_n,
  output logic              busy
`ifdef RESET_SEQUENCER_CAUSE_EN
  ,
  output logic [1:0]        last_cause
`endif
);

  localparam int HW = (HOLD_CYCLES > 1)     ? $clog2(HOLD_CYCLES)     : 1;
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int SW = (STAGGER_CYCLES > 1)  ? $clog2(STAGGER_CYCLES)  : 1;
  localparam int CW = (NUM_CH > 1)          ? $clog2(NUM_CH)          : 1;

  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW-1:0] STAG_LAST = SW'(STAGGER_CYCLES - 1);
  localparam logic [CW-1:0] CH_LAST   = CW'(NUM_CH - 1);

  typedef enum logic [1:0] {
    WAIT_START = 2'd0,
    HOLD       = 2'd1,
    RELEASE    = 2'd2,
    RUN        = 2'd3
  } state_t;

  logic [1:0]        sync_q;
  logic              armed_q, armed_d;
  logic [DW-1:0]     deb_cnt_q, deb_cnt_d;
  logic              trig_q, trig_d;

  state_t            state_q, state_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic [SW-1:0]     stag_q, stag_d;
  logic [CW-1:0]     ch_q, ch_d;
  logic [NUM_CH-1:0] rn_q, rn_d;
  logic              busy_q, busy_d;
`ifdef RESET_SEQUENCER_CAUSE_EN
  logic [1:0]        cause_q, cause_d;
`endif

  // Debouncer counts runs of the level it is waiting for: low when armed, high when not.
  always_comb begin
    armed_d   = armed_q;
    deb_cnt_d = deb_cnt_q;
    trig_d    = 1'b0;
    if (sync_q[1] != armed_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        trig_d    = armed_q;
        armed_d   = ~armed_q;
        deb_cnt_d = '0;
      end else begin
        deb_cnt_d = deb_cnt_q + DW'(1);
      end
    end else begin
      deb_cnt_d = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    stag_d  = stag_q;
    ch_d    = ch_q;
    rn_d    = rn_q;
`ifdef RESET_SEQUENCER_CAUSE_EN
    cause_d = cause_q;
`endif
    if (!fpgaStart) begin
      state_d = WAIT_START;
      hold_d  = '0;
      stag_d  = '0;
      ch_d    = '0;
      rn_d    = '0;
    end else if ((state_q != WAIT_START) && (trig_q || ext_req)) begin
      state_d = HOLD;
      hold_d  = '0;
      stag_d  = '0;
      ch_d    = '0;
      rn_d    = '0;
`ifdef RESET_SEQUENCER_CAUSE_EN
      cause_d = {ext_req, trig_q};
`endif
    end else begin
      case (state_q)
        WAIT_START: begin
          state_d = HOLD;
          hold_d  = '0;
          rn_d    = '0;
`ifdef RESET_SEQUENCER_CAUSE_EN
          cause_d = 2'd0;
`endif
        end
        HOLD: begin
          if (hold_q == HOLD_LAST) begin
            rn_d    = NUM_CH'(1);
            stag_d  = '0;
            ch_d    = CW'(1);
            state_d = (NUM_CH == 1) ? RUN : RELEASE;
          end else begin
            hold_d = hold_q + HW'(1);
          end
        end
        RELEASE: begin
          if (stag_q == STAG_LAST) begin
            rn_d   = rn_q | (NUM_CH'(1) << ch_q);
            stag_d = '0;
            if (ch_q == CH_LAST) begin
              state_d = RUN;
            end else begin
              ch_d = ch_q + CW'(1);
            end
          end else begin
            stag_d = stag_q + SW'(1);
          end
        end
        default: begin
        end
      endcase
    end
    busy_d = ~&rn_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q    <= 2'b11;
      armed_q   <= 1'b1;
      deb_cnt_q <= '0;
      trig_q    <= 1'b0;
      state_q   <= WAIT_START;
      hold_q    <= '0;
      stag_q    <= '0;
      ch_q      <= '0;
      rn_q      <= '0;
      busy_q    <= 1'b1;
`ifdef RESET_SEQUENCER_CAUSE_EN
      cause_q   <= 2'd0;
`endif
    end else begin
      sync_q    <= {sync_q[0], fpga_but1};
      armed_q   <= armed_d;
      deb_cnt_q <= deb_cnt_d;
      trig_q    <= trig_d;
      state_q   <= state_d;
      hold_q    <= hold_d;
      stag_q    <= stag_d;
      ch_q      <= ch_d;
      rn_q      <= rn_d;
      busy_q    <= busy_d;
`ifdef RESET_SEQUENCER_CAUSE_EN
      cause_q   <= cause_d;
`endif
    end
  end

  assign reset_n = rn_q;
  assign busy    = busy_q;
`ifdef RESET_SEQUENCER_CAUSE_EN
  assign last_cause = cause_q;
`endif

endmodule
`default_nettype wire
